// File: rtl/conv_arbiter.sv
// conv_arbiter
// Two-requester round-robin front end for one shared float-to-fixed converter.
// A grant in IDLE latches the winner's operand. ISSUE then clears and starts
// the converter. WAIT polls the converter's sticky ready flag under a timeout.
// RESP returns the result, or a timeout error, to the owning requester.
//
// Ports
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_req_valid[1:0]      per-requester request
//   i_req_float0/1        IEEE-754 single operand of requester 0 / 1
//   o_req_ready[1:0]      one-cycle accept pulse to the granted requester
//   o_resp_valid[1:0]     one-cycle response pulse to the owner
//   o_resp_fxp            fixed-point result (held until the next response)
//   o_resp_err            timeout flag (held until the next response)
//   o_conv_start          start pulse to the converter
//   o_conv_clr            converter reset (also high while i_rst is high)
//   o_conv_float          registered converter operand
//   i_conv_fxp            converter result
//   i_conv_ready          converter done flag, sticky until o_conv_clr
module conv_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_req_valid,
    input  logic [31:0] i_req_float0,
    input  logic [31:0] i_req_float1,
    output logic [1:0]  o_req_ready,
    output logic [1:0]  o_resp_valid,
    output logic [31:0] o_resp_fxp,
    output logic        o_resp_err,
    output logic        o_conv_start,
    output logic        o_conv_clr,
    output logic [31:0] o_conv_float,
    input  logic [31:0] i_conv_fxp,
    input  logic        i_conv_ready
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last_grant;
    logic          r_owner;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_conv_float;
    logic [31:0]   r_resp_fxp;
    logic          r_resp_err;

    logic          w_grant;
    logic          w_req_any;
    logic          w_hit;
    logic          w_timeout;

    assign w_req_any = |i_req_valid;

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        w_grant = 1'b0;
        if (i_req_valid == 2'b10)
            w_grant = 1'b1;
        else if (i_req_valid == 2'b11)
            w_grant = ~r_last_grant;
    end

    // At count 0 the converter's sticky flag may still show the previous job.
    assign w_hit     = (r_cnt != '0) && i_conv_ready;
    assign w_timeout = (r_cnt == CNT_LAST);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req_any) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_hit || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs; everything is forced quiet during reset except the converter clear.
    always_comb begin
        o_req_ready  = 2'b00;
        o_resp_valid = 2'b00;
        o_conv_start = 1'b0;
        o_conv_clr   = i_rst;
        o_conv_float = i_rst ? 32'd0 : r_conv_float;
        o_resp_fxp   = i_rst ? 32'd0 : r_resp_fxp;
        o_resp_err   = i_rst ? 1'b0  : r_resp_err;
        if (!i_rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) o_req_ready[w_grant] = 1'b1;
                end
                S_ISSUE: begin
                    o_conv_start = 1'b1;
                    o_conv_clr   = 1'b1;
                end
                S_RESP: o_resp_valid[r_owner] = 1'b1;
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_cnt        <= '0;
            r_conv_float <= 32'd0;
            r_resp_fxp   <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_owner      <= w_grant;
                        r_conv_float <= w_grant ? i_req_float1 : i_req_float0;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    // Ready takes priority over the timeout on the last cycle.
                    if (w_hit) begin
                        r_resp_fxp <= i_conv_fxp;
                        r_resp_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_resp_fxp <= 32'd0;
                        r_resp_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: r_last_grant <= r_owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_arbiter.sv
module tb_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] f0, f1;
    logic [1:0]  req_ready, resp_valid;
    logic [31:0] resp_fxp, conv_float, conv_fxp;
    logic        resp_err, conv_start, conv_clr, conv_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conv_arbiter #(.TIMEOUT(64)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid),
        .i_req_float0(f0), .i_req_float1(f1),
        .o_req_ready(req_ready), .o_resp_valid(resp_valid),
        .o_resp_fxp(resp_fxp), .o_resp_err(resp_err),
        .o_conv_start(conv_start), .o_conv_clr(conv_clr),
        .o_conv_float(conv_float), .i_conv_fxp(conv_fxp),
        .i_conv_ready(conv_ready)
    );

    // Converter model: result is the operand with its halves swapped, ready
    // m_delay cycles after start; sticky until clr. stale_force imitates a
    // flag that is slow to clear.
    int          m_delay = 5;
    int          m_cnt = 0;
    logic        m_busy, m_rdy;
    logic [31:0] m_res, m_op;
    logic        stale_force = 1'b0;

    assign conv_ready = m_rdy | stale_force;
    assign conv_fxp   = stale_force ? 32'hDEADBEEF : m_res;

    always @(posedge clk) begin
        if (conv_clr) begin
            m_rdy  <= 1'b0;
            m_res  <= 32'd0;
            m_busy <= 1'b0;
        end
        if (conv_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_op   <= conv_float;
        end else if (m_busy && !m_rdy) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_delay) begin
                m_rdy <= 1'b1;
                m_res <= {m_op[15:0], m_op[31:16]};
            end
        end
    end

    // Steps cycles until a response appears; lat = cycles since accept, -1 if none.
    task automatic wait_resp(input int start, output int lat, output logic [1:0] rv,
                             output logic [31:0] fxp, output logic err);
        lat = -1; rv = 2'b00; fxp = 32'd0; err = 1'b0;
        for (int c = start + 1; c <= start + 200; c++) begin
            @(negedge clk); #1;
            if (resp_valid != 2'b00) begin
                lat = c; rv = resp_valid; fxp = resp_fxp; err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; req_valid = 2'b11; #1;
        n_cmp++;
        if ({req_ready, resp_valid, conv_start, conv_clr} !== 6'b000001) begin
            n_bad++; $display("FAIL reset_pulses: got %b want 000001", {req_ready, resp_valid, conv_start, conv_clr});
        end
        n_cmp++;
        if ({conv_float, resp_fxp, resp_err} !== 65'd0) begin
            n_bad++; $display("FAIL reset_data: got %h/%h/%b want 0", conv_float, resp_fxp, resp_err);
        end
        @(negedge clk);
        rst = 1'b0; req_valid = 2'b00; #1;
        n_cmp++;
        if ({req_ready, resp_valid, conv_start, conv_clr} !== 6'b000000) begin
            n_bad++; $display("FAIL idle_quiet: got %b want 000000", {req_ready, resp_valid, conv_start, conv_clr});
        end
    endtask

    task automatic test_single;
        int lat; logic [1:0] rv; logic [31:0] fxp; logic err;
        m_delay = 5; f0 = 32'h3F800000;
        @(negedge clk); req_valid = 2'b01; #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_accept: got %b want 01", req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        n_cmp++;
        if ({conv_start, conv_clr, conv_float} !== {2'b11, 32'h3F800000}) begin
            n_bad++; $display("FAIL single_issue: got %b%b %h want 11 3f800000", conv_start, conv_clr, conv_float);
        end
        wait_resp(1, lat, rv, fxp, err);
        n_cmp++;
        if ({lat, rv, fxp, err} !== {32'd8, 2'b01, 32'h00003F80, 1'b0}) begin
            n_bad++; $display("FAIL single_resp: got lat %0d rv %b fxp %h err %b want 8 01 00003f80 0", lat, rv, fxp, err);
        end
        n_cmp++;
        if (conv_float !== 32'h3F800000) begin n_bad++; $display("FAIL single_float_hold: got %h want 3f800000", conv_float); end
        @(negedge clk); #1;
        n_cmp++;
        if ({resp_valid, resp_fxp, resp_err} !== {2'b00, 32'h00003F80, 1'b0}) begin
            n_bad++; $display("FAIL single_hold: got %b %h %b want 00 00003f80 0", resp_valid, resp_fxp, resp_err);
        end
    endtask

    task automatic test_tie;
        int lat; logic [1:0] rv; logic [31:0] fxp; logic err; logic [1:0] exp_g; logic [31:0] exp_f;
        m_delay = 1; f0 = 32'h3F800000; f1 = 32'h40000000;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
            exp_f = (k % 2 == 1) ? 32'h00004000 : 32'h00003F80;
            #1;
            n_cmp++;
            if (req_ready !== exp_g) begin n_bad++; $display("FAIL tie_grant%0d: got %b want %b", k, req_ready, exp_g); end
            @(negedge clk); #1;
            n_cmp++;
            if (req_ready !== 2'b00) begin n_bad++; $display("FAIL tie_busy%0d: got %b want 00", k, req_ready); end
            wait_resp(1, lat, rv, fxp, err);
            n_cmp++;
            if ({lat, rv, fxp, err} !== {32'd4, exp_g, exp_f, 1'b0}) begin
                n_bad++; $display("FAIL tie_resp%0d: got lat %0d rv %b fxp %h err %b want 4 %b %h 0", k, lat, rv, fxp, err, exp_g, exp_f);
            end
            @(negedge clk);
            if (k == 3) req_valid = 2'b00;
        end
    endtask

    task automatic test_stale;
        int lat; logic [1:0] rv; logic [31:0] fxp; logic err;
        m_delay = 4; f0 = 32'h40490FDB;
        @(negedge clk); stale_force = 1'b1; req_valid = 2'b01; #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin n_bad++; $display("FAIL stale_accept: got %b want 01", req_ready); end
        @(negedge clk); req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk); stale_force = 1'b0;
        wait_resp(3, lat, rv, fxp, err);
        n_cmp++;
        if ({lat, rv, fxp, err} !== {32'd7, 2'b01, 32'h0FDB4049, 1'b0}) begin
            n_bad++; $display("FAIL stale_resp: got lat %0d rv %b fxp %h err %b want 7 01 0fdb4049 0", lat, rv, fxp, err);
        end
    endtask

    task automatic test_timeout;
        int lat; logic [1:0] rv; logic [31:0] fxp; logic err;
        m_delay = 1000; f0 = 32'h12345678;
        @(negedge clk); req_valid = 2'b01; #1;
        @(negedge clk); req_valid = 2'b00;
        wait_resp(1, lat, rv, fxp, err);
        n_cmp++;
        if ({lat, rv, fxp, err} !== {32'd66, 2'b01, 32'h0, 1'b1}) begin
            n_bad++; $display("FAIL timeout_resp: got lat %0d rv %b fxp %h err %b want 66 01 0 1", lat, rv, fxp, err);
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({resp_valid, resp_fxp, resp_err} !== {2'b00, 32'h0, 1'b1}) begin
            n_bad++; $display("FAIL timeout_hold: got %b %h %b want 00 0 1", resp_valid, resp_fxp, resp_err);
        end
    endtask

    task automatic test_last_wait;
        int lat; logic [1:0] rv; logic [31:0] fxp; logic err;
        m_delay = 63; f0 = 32'hC2C80000;
        @(negedge clk); req_valid = 2'b01; #1;
        @(negedge clk); req_valid = 2'b00;
        wait_resp(1, lat, rv, fxp, err);
        n_cmp++;
        if ({lat, rv, fxp, err} !== {32'd66, 2'b01, 32'h0000C2C8, 1'b0}) begin
            n_bad++; $display("FAIL last_wait_resp: got lat %0d rv %b fxp %h err %b want 66 01 0000c2c8 0", lat, rv, fxp, err);
        end
    endtask

    task automatic test_rst_mid;
        int lat; logic [1:0] rv; logic [31:0] fxp; logic err; int pulses;
        m_delay = 1000; f1 = 32'h40400000;
        @(negedge clk); req_valid = 2'b10; #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin n_bad++; $display("FAIL rstmid_accept: got %b want 10", req_ready); end
        @(negedge clk); req_valid = 2'b00;
        repeat (10) @(negedge clk);
        rst = 1'b1; #1;
        n_cmp++;
        if ({req_ready, resp_valid, conv_start, conv_clr, conv_float} !== {6'b000001, 32'h0}) begin
            n_bad++; $display("FAIL rstmid_outputs: got %b %h want 000001 0", {req_ready, resp_valid, conv_start, conv_clr}, conv_float);
        end
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        repeat (80) begin
            @(negedge clk); #1;
            if (resp_valid != 2'b00) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin n_bad++; $display("FAIL rstmid_no_resp: got %0d pulses want 0", pulses); end
        m_delay = 2; req_valid = 2'b11; #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rstmid_pref0: got %b want 01", req_ready); end
        @(negedge clk); req_valid = 2'b00;
        wait_resp(1, lat, rv, fxp, err);
        n_cmp++;
        if ({lat, rv, fxp, err} !== {32'd5, 2'b01, 32'h0000C2C8, 1'b0}) begin
            n_bad++; $display("FAIL rstmid_after: got lat %0d rv %b fxp %h err %b want 5 01 0000c2c8 0", lat, rv, fxp, err);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 2'b00; f0 = 32'd0; f1 = 32'd0;
        test_reset();
        test_single();
        test_tie();
        test_stale();
        test_timeout();
        test_last_wait();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_arbiter.md
CONV_ARBITER -- requirements
Module: conv_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum WAIT cycles before a conversion is abandoned.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester request; bit i belongs to requester i.
REQ-005 req_float0, req_float1  input  32  IEEE-754 single operand of requester 0 / 1.
REQ-006 req_ready  output  2  one-cycle accept pulse to the granted requester.
REQ-007 resp_valid  output  2  one-cycle response pulse to the owning requester.
REQ-008 resp_fxp  output  32  fixed-point result; valid only while resp_valid is non-zero.
REQ-009 resp_err  output  1  timeout flag, qualified by resp_valid.
REQ-010 conv_start  output  1  start pulse to the shared float-to-fixed converter.
REQ-011 conv_clr  output  1  drives the converter rst; clears its sticky ready flag and result.
REQ-012 conv_float  output  32  operand to converter; registered.
REQ-013 conv_fxp  input  32  converter result.
REQ-014 conv_ready  input  1  converter done flag; sticky until conv_clr.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, RESP, encoded in 2 bits.
REQ-016 IDLE: if req_valid is 0, SHALL remain in IDLE with all pulses low.
REQ-017 IDLE with a request: SHALL grant by round-robin, preferring the requester other than last_grant; a single requesting bit wins regardless of last_grant.
REQ-018 Grant cycle: req_ready[g] = 1 combinationally; req_float_g latched into conv_float; g latched as owner; next state ISSUE.
REQ-019 ISSUE (exactly 1 cycle): conv_clr = 1 and conv_start = 1; wait counter cleared to 0; next state WAIT.
REQ-020 conv_float SHALL stay constant from ISSUE through RESP.
REQ-021 WAIT: counter increments each cycle; conv_ready is ignored while counter == 0 because the sticky flag is still clearing.
REQ-022 WAIT, counter >= 1 and conv_ready = 1: capture conv_fxp into the result register, err = 0, next state RESP.
REQ-023 WAIT, counter == TIMEOUT-1 and conv_ready = 0: result = 0, err = 1, next state RESP. If ready and timeout coincide, ready wins.
REQ-024 RESP (exactly 1 cycle): resp_valid[owner] = 1; resp_fxp and resp_err driven from registers; last_grant <= owner; next state IDLE.
REQ-025 resp_fxp and resp_err SHALL hold their last values after RESP until the next RESP.
REQ-026 Minimum latency: accept at cycle T, ISSUE at T+1, earliest capture at T+3, resp_valid at T+4. Requests are not accepted outside IDLE.
REQ-027 req_valid deasserted by a requester after acceptance SHALL have no effect on the in-flight operation.
REQ-028 The counter SHALL be $clog2(TIMEOUT) bits wide and never wrap within WAIT.

Reset
REQ-029 rst = 1 at a clock edge: state <= IDLE; last_grant <= 1 (requester 0 wins the first tie); counter, conv_float, resp_fxp and resp_err <= 0.
REQ-030 During rst, all outputs SHALL be 0, except conv_clr = 1 so that the converter is cleared alongside the arbiter.
REQ-031 rst asserted mid-operation (ISSUE, WAIT or RESP) SHALL abort with no resp_valid pulse; the aborted request is lost.

Verification
REQ-032 Single request: req_valid = 01, float 0x3F800000 (1.0), converter model ready after 5 cycles -> req_ready = 01 at T; resp_valid = 01 with resp_fxp = model value and resp_err = 0.
REQ-033 Tie: req_valid = 11 held continuously after reset -> grants in order 0, 1, 0, 1; each resp_valid bit matches its grant.
REQ-034 Stale ready: conv_ready held 1 from the previous job through ISSUE -> not captured at counter == 0; capture occurs only once the model reasserts ready.
REQ-035 Timeout: converter model never asserts ready -> resp_valid pulses 1 + 1 + 64 cycles after accept, with resp_err = 1 and resp_fxp = 0.
REQ-036 Ready on the last WAIT cycle (counter == 63) -> resp_err = 0 and the data is captured.
REQ-037 rst pulsed during WAIT -> no resp_valid; next request accepted from IDLE, with requester 0 preferred.
